// File: rtl/mold_pkg.sv
// Shared widths, header payload type and arbiter states for the MoldUDP64 feed arbiter.
package mold_pkg;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_KEEP_W = AXI_DATA_W / 8;
  localparam int unsigned SID_W      = 80;
  localparam int unsigned SEQ_W      = 64;
  localparam int unsigned ML_W       = 16;
  // Seq straddles two beats: low part in beat1[63:16], high part in beat2[15:0].
  localparam int unsigned SEQ_B1_W   = AXI_DATA_W - 16;
  localparam int unsigned SEQ_B2_W   = SEQ_W - SEQ_B1_W;
  localparam int unsigned CNT_LSB    = SEQ_B2_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_BODY
  } arb_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [ML_W-1:0]  cnt;
  } mold_hdr_t;

  function automatic logic [SEQ_W-1:0] seq_max(input logic [SEQ_W-1:0] a,
                                               input logic [SEQ_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/mold_seq_track.sv
// Expected-sequence tracker: classifies each header as gap/dup and advances the expectation.
module mold_seq_track
  import mold_pkg::*;
(
  input  logic      clk,
  input  logic      nreset,
  input  logic      hdr_fire_i,
  input  mold_hdr_t hdr_i,
  output logic      gap_o,
  output logic      dup_o
);
  logic [SEQ_W-1:0] exp_q, exp_d, seq_end;
  logic             exp_v_q, exp_v_d;
  logic             gap_q, gap_d, dup_q, dup_d;

  // A heartbeat (cnt 0) reduces to max(expected, seq) since seq_end == seq.
  always_comb begin
    exp_d   = exp_q;
    exp_v_d = exp_v_q;
    gap_d   = gap_q;
    dup_d   = dup_q;
    seq_end = hdr_i.seq + SEQ_W'(hdr_i.cnt);
    if (hdr_fire_i) begin
      exp_v_d = 1'b1;
      if (!exp_v_q) begin
        gap_d = 1'b0;
        dup_d = 1'b0;
        exp_d = seq_end;
      end else begin
        gap_d = hdr_i.seq > exp_q;
        dup_d = hdr_i.seq < exp_q;
        if (hdr_i.cnt != '1) begin
          exp_d = seq_max(exp_q, seq_end);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      exp_q   <= '0;
      exp_v_q <= 1'b0;
      gap_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      exp_v_q <= exp_v_d;
      gap_q   <= gap_d;
      dup_q   <= dup_d;
    end
  end

  assign gap_o = gap_q;
  assign dup_o = dup_q;
endmodule

// File: rtl/mold_feed_arb.sv
// Packet-locked arbiter between two MoldUDP64 feeds with header extraction and seq tracking.
module mold_feed_arb #(
  parameter int unsigned AXI_DATA_W = mold_pkg::AXI_DATA_W,
  parameter int unsigned AXI_KEEP_W = AXI_DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      s0_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0]     s0_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0]     s0_axis_tdata_i,
  input  logic                      s0_axis_tlast_i,
  input  logic                      s0_axis_tuser_i,
  output logic                      s0_axis_tready_o,
  input  logic                      s1_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0]     s1_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0]     s1_axis_tdata_i,
  input  logic                      s1_axis_tlast_i,
  input  logic                      s1_axis_tuser_i,
  output logic                      s1_axis_tready_o,
  output logic                      m_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0]     m_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0]     m_axis_tdata_o,
  output logic                      m_axis_tlast_o,
  output logic                      m_axis_tuser_o,
  input  logic                      m_axis_tready_i,
  output logic                      grant_v_o,
  output logic                      grant_o,
  output logic                      hdr_v_o,
  output logic                      hdr_src_o,
  output logic [mold_pkg::SEQ_W-1:0] hdr_seq_o,
  output logic [mold_pkg::ML_W-1:0]  hdr_cnt_o,
  output logic                      hdr_gap_o,
  output logic                      hdr_dup_o
);
  import mold_pkg::*;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d, grant_v_q, grant_v_d;
  logic                last_b_q, last_b_d;
  logic [SEQ_B1_W-1:0] seq_b1_q, seq_b1_d;
  logic                hdr_v_q, hdr_v_d, hdr_src_q, hdr_src_d;
  mold_hdr_t           hdr_q, hdr_d, hdr_new;
  logic                busy, beat, hdr_fire;
  logic                sel_tvalid, sel_tlast;
  logic [AXI_DATA_W-1:0] sel_tdata;

  // Output path follows the locked feed combinationally; nothing moves while idle.
  assign busy       = (state_q != ST_IDLE);
  assign sel_tvalid = grant_q ? s1_axis_tvalid_i : s0_axis_tvalid_i;
  assign sel_tlast  = grant_q ? s1_axis_tlast_i  : s0_axis_tlast_i;
  assign sel_tdata  = grant_q ? s1_axis_tdata_i  : s0_axis_tdata_i;

  assign m_axis_tvalid_o  = busy & sel_tvalid;
  assign m_axis_tkeep_o   = grant_q ? s1_axis_tkeep_i : s0_axis_tkeep_i;
  assign m_axis_tdata_o   = sel_tdata;
  assign m_axis_tlast_o   = sel_tlast;
  assign m_axis_tuser_o   = grant_q ? s1_axis_tuser_i : s0_axis_tuser_i;
  assign s0_axis_tready_o = busy & ~grant_q & m_axis_tready_i;
  assign s1_axis_tready_o = busy &  grant_q & m_axis_tready_i;
  assign beat             = m_axis_tvalid_o & m_axis_tready_i;

  assign hdr_new.seq = {sel_tdata[SEQ_B2_W-1:0], seq_b1_q};
  assign hdr_new.cnt = sel_tdata[CNT_LSB +: ML_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grant_v_d = grant_v_q;
    last_b_d  = last_b_q;
    seq_b1_d  = seq_b1_q;
    hdr_v_d   = 1'b0;
    hdr_src_d = hdr_src_q;
    hdr_d     = hdr_q;
    hdr_fire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid_i | s1_axis_tvalid_i) begin
          grant_d   = (s0_axis_tvalid_i & s1_axis_tvalid_i) ? ~last_b_q : s1_axis_tvalid_i;
          grant_v_d = 1'b1;
          state_d   = ST_HDR0;
        end
      end
      ST_HDR0: if (beat) state_d = ST_HDR1;
      ST_HDR1: begin
        if (beat) begin
          seq_b1_d = sel_tdata[AXI_DATA_W-1 -: SEQ_B1_W];
          state_d  = ST_HDR2;
        end
      end
      ST_HDR2: begin
        if (beat) begin
          hdr_fire  = 1'b1;
          hdr_v_d   = 1'b1;
          hdr_src_d = grant_q;
          hdr_d     = hdr_new;
          state_d   = ST_BODY;
        end
      end
      ST_BODY: state_d = ST_BODY;
      default: state_d = ST_IDLE;
    endcase
    // tlast closes the packet from any header stage, runts included.
    if (beat && sel_tlast) begin
      state_d   = ST_IDLE;
      grant_v_d = 1'b0;
      last_b_d  = grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      grant_v_q <= 1'b0;
      last_b_q  <= 1'b1;
      seq_b1_q  <= '0;
      hdr_v_q   <= 1'b0;
      hdr_src_q <= 1'b0;
      hdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      grant_v_q <= grant_v_d;
      last_b_q  <= last_b_d;
      seq_b1_q  <= seq_b1_d;
      hdr_v_q   <= hdr_v_d;
      hdr_src_q <= hdr_src_d;
      hdr_q     <= hdr_d;
    end
  end

  mold_seq_track u_seq_track (
    .clk        (clk),
    .nreset     (nreset),
    .hdr_fire_i (hdr_fire),
    .hdr_i      (hdr_new),
    .gap_o      (hdr_gap_o),
    .dup_o      (hdr_dup_o)
  );

  assign grant_v_o = grant_v_q;
  assign grant_o   = grant_q;
  assign hdr_v_o   = hdr_v_q;
  assign hdr_src_o = hdr_src_q;
  assign hdr_seq_o = hdr_q.seq;
  assign hdr_cnt_o = hdr_q.cnt;
endmodule

// File: doc/mold_feed_arb.md
MOLD_FEED_ARB -- requirements
Module: mold_feed_arb

Interface
REQ-001 Parameter AXI_DATA_W, default 64: AXI-stream data width; only 64 is supported.
REQ-002 Parameter AXI_KEEP_W, default AXI_DATA_W/8: tkeep width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 nreset  in  1  reset; one clock, synchronous, active-high (asserted = 1).
REQ-005 s0_axis_tvalid_i/tkeep_i/tdata_i/tlast_i/tuser_i  in  1/8/64/1/1  feed A UDP payload stream.
REQ-006 s0_axis_tready_o  out  1  feed A ready.
REQ-007 s1_axis_tvalid_i/tkeep_i/tdata_i/tlast_i/tuser_i  in  1/8/64/1/1  feed B UDP payload stream.
REQ-008 s1_axis_tready_o  out  1  feed B ready.
REQ-009 m_axis_tvalid_o/tkeep_o/tdata_o/tlast_o/tuser_o  out  1/8/64/1/1  muxed stream to the MoldUDP64 parser.
REQ-010 m_axis_tready_i  in  1  parser ready.
REQ-011 grant_v_o  out  1  a packet is locked to a feed.
REQ-012 grant_o  out  1  locked feed (0 = A, 1 = B).
REQ-013 hdr_v_o  out  1  one-cycle pulse: header fields valid.
REQ-014 hdr_src_o, hdr_seq_o, hdr_cnt_o  out  1/64/16  feed, sequence number, message count of the current packet.
REQ-015 hdr_gap_o, hdr_dup_o  out  1/1  seq above / below the expected sequence number; qualified by hdr_v_o.

Function
REQ-016 States: IDLE, HDR0, HDR1, HDR2, BODY; an accepted beat is tvalid & tready on the granted port.
REQ-017 IDLE: with one feed valid, grant it; with both valid, grant the feed opposite the last-served feed (A after reset); transition to HDR0 in the same cycle; no beat is forwarded while in IDLE.
REQ-018 In HDR0..BODY, the m_axis outputs equal the granted s-port inputs combinationally; granted tready_o equals m_axis_tready_i; the non-granted tready_o is 0.
REQ-019 In IDLE, m_axis_tvalid_o, s0_axis_tready_o and s1_axis_tready_o are 0.
REQ-020 Each accepted beat advances HDR0->HDR1->HDR2->BODY; BODY holds until tlast.
REQ-021 Accepted tlast in any state returns to IDLE next cycle, sets last-served to the granted feed and clears grant_v_o.
REQ-022 Header bit packing: seq = {beat2[15:0], beat1[63:16]}; cnt = beat2[31:16]; session id (beat0, beat1[15:0]) is ignored.
REQ-023 beat1[63:16] is registered in HDR1; hdr_v_o pulses in the cycle after the HDR2 beat is accepted, including when that beat carries tlast.
REQ-024 Packet ending before HDR2 (runt): no hdr_v_o; expected seq unchanged.
REQ-025 Expected seq register (64-bit, mod 2^64) plus a valid flag. First header after reset: gap=0, dup=0; expected := seq+cnt.
REQ-026 Later headers: gap = seq > expected; dup = seq < expected; expected := max(expected, seq+cnt), unsigned.
REQ-027 cnt==16'hFFFF (end of session): expected unchanged; gap and dup are computed normally.
REQ-028 cnt==0 (heartbeat): gap/dup are computed; expected := max(expected, seq).
REQ-029 tuser is passed through untouched; the arbiter never drops or modifies beats.

Reset
REQ-030 While nreset=1: state=IDLE, grant_v_o=0, grant_o=0, last-served=B, hdr_v_o=0, hdr_seq_o=0, hdr_cnt_o=0, hdr_gap_o=0, hdr_dup_o=0, hdr_src_o=0, expected invalid.
REQ-031 Reset mid-packet aborts the packet; all outputs take their reset values in the next cycle.

Structure
REQ-032 Shared package mold_pkg holds AXI_DATA_W, the header field widths (SID_W=80, SEQ_W=64, ML_W=16) and the arbiter state enum.
REQ-033 Sub-module mold_seq_track contains the expected-seq register and the gap/dup/max logic; grant and FSM stay at top level.

Verification
REQ-034 Both feeds valid after reset, A packet 4 beats -> A forwarded first, then B; grant_o 0 then 1; no beat interleaving.
REQ-035 A packet: seq=0x10, cnt=3, then B: seq=0x10, cnt=3 -> second hdr_v_o with dup=1; expected stays 0x13.
REQ-036 Expected 0x13, packet seq=0x20 cnt=1 -> gap=1; expected becomes 0x21.
REQ-037 m_axis_tready_i toggling 1,0,1 during HDR1 -> no lost or duplicated beat; hdr_seq_o correct; hdr_v_o exactly once.
REQ-038 2-beat runt with tlast -> no hdr_v_o; IDLE next cycle; other feed granted.
REQ-039 nreset=1 during BODY -> all outputs at reset values next cycle; next packet is treated as first (gap=0, dup=0).
